axil_reg_manager: RTL and testbench

// - Synthesizable AXI4-Lite manager that turns single-word register commands into bus transactions.
// - Supported commands: READ, WRITE, SET-bits, CLEAR-bits, POLL-until-bits-set.
// - Sits between a CPU-less sequencer or test controller and any AXI4-Lite CSR block, e.g. the SPI IP register file.
// - One command in flight at a time.

---
 rtl/axil_reg_manager_pkg.sv | 25 ++
 rtl/axil_reg_manager.sv | 211 +++++++++++++++++++++
 tb/tb_axil_reg_manager.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_reg_manager_pkg.sv
// Shared types for the AXI4-Lite register-command manager: command opcodes,
// FSM states and the AXI response code treated as success.
package axil_reg_manager_pkg;

   typedef enum logic [2:0] {
      OP_READ  = 3'd0,
      OP_WRITE = 3'd1,
      OP_SET   = 3'd2,
      OP_CLEAR = 3'd3,
      OP_POLL  = 3'd4
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_AR,
      S_R,
      S_AW_W,
      S_B,
      S_GAP,
      S_DONE
   } state_t;

   localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axil_reg_manager.sv
// AXI4-Lite manager executing one register command at a time:
// READ, WRITE, read-modify-write SET/CLEAR, and POLL-until-bits-set.
module axil_reg_manager
   import axil_reg_manager_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 8,
   parameter int POLL_CYCLES = 100
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [2:0]                cmd_op,
   input  logic [ADDR_WIDTH-1:0]     cmd_reg,
   input  logic [DATA_WIDTH-1:0]     cmd_data,
   output logic                      rsp_valid,
   output logic [DATA_WIDTH-1:0]     rsp_data,
   output logic                      rsp_err,
   output logic [ADDR_WIDTH-1:0]     m_awaddr,
   output logic [2:0]                m_awprot,
   output logic                      m_awvalid,
   input  logic                      m_awready,
   output logic [DATA_WIDTH-1:0]     m_wdata,
   output logic [DATA_WIDTH/8-1:0]   m_wstrb,
   output logic                      m_wvalid,
   input  logic                      m_wready,
   input  logic [1:0]                m_bresp,
   input  logic                      m_bvalid,
   output logic                      m_bready,
   output logic [ADDR_WIDTH-1:0]     m_araddr,
   output logic [2:0]                m_arprot,
   output logic                      m_arvalid,
   input  logic                      m_arready,
   input  logic [DATA_WIDTH-1:0]     m_rdata,
   input  logic [1:0]                m_rresp,
   input  logic                      m_rvalid,
   output logic                      m_rready
);

   localparam int STRIDE = DATA_WIDTH / 8;
   localparam int CNT_W  = $clog2(POLL_CYCLES + 1);

   state_t                  state_q, state_d;
   op_t                     op_q, op_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   mask_q, mask_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   acc_q, acc_d;
   logic                    err_q, err_d;
   logic                    awvalid_q, awvalid_d;
   logic                    wvalid_q, wvalid_d;
   logic                    arvalid_q, arvalid_d;
   logic                    bready_q, bready_d;
   logic                    rready_q, rready_d;
   logic [CNT_W-1:0]        gap_q, gap_d;
   logic                    rd_err;

   assign rd_err = (m_rresp != RESP_OKAY);

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      addr_d    = addr_q;
      mask_d    = mask_q;
      wdata_d   = wdata_q;
      acc_d     = acc_q;
      err_d     = err_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      arvalid_d = arvalid_q;
      bready_d  = bready_q;
      rready_d  = rready_q;
      gap_d     = gap_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d   = op_t'(cmd_op);
               addr_d = ADDR_WIDTH'(cmd_reg * ADDR_WIDTH'(STRIDE));
               mask_d = cmd_data;
               err_d  = 1'b0;
               case (cmd_op)
                  OP_READ, OP_SET, OP_CLEAR, OP_POLL: begin
                     arvalid_d = 1'b1;
                     state_d   = S_AR;
                  end
                  OP_WRITE: begin
                     wdata_d   = cmd_data;
                     awvalid_d = 1'b1;
                     wvalid_d  = 1'b1;
                     state_d   = S_AW_W;
                  end
                  default: begin
                     err_d   = 1'b1;
                     state_d = S_DONE;
                  end
               endcase
            end
         end
         S_AR: begin
            if (m_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_R;
            end
         end
         S_R: begin
            if (m_rvalid) begin
               rready_d = 1'b0;
               acc_d    = m_rdata;
               err_d    = err_q | rd_err;
               case (op_q)
                  OP_SET, OP_CLEAR: begin
                     wdata_d   = (op_q == OP_SET) ? (m_rdata | mask_q) : (m_rdata & ~mask_q);
                     awvalid_d = 1'b1;
                     wvalid_d  = 1'b1;
                     state_d   = S_AW_W;
                  end
                  OP_POLL: begin
                     // An error response ends the poll so a broken target cannot hang us
                     if (rd_err || ((m_rdata & mask_q) == mask_q)) begin
                        state_d = S_DONE;
                     end else begin
                        gap_d   = CNT_W'(POLL_CYCLES);
                        state_d = S_GAP;
                     end
                  end
                  default: state_d = S_DONE;
               endcase
            end
         end
         S_AW_W: begin
            if (awvalid_q && m_awready) awvalid_d = 1'b0;
            if (wvalid_q && m_wready)   wvalid_d  = 1'b0;
            if ((!awvalid_q || m_awready) && (!wvalid_q || m_wready)) begin
               bready_d = 1'b1;
               state_d  = S_B;
            end
         end
         S_B: begin
            if (m_bvalid) begin
               bready_d = 1'b0;
               err_d    = err_q | (m_bresp != RESP_OKAY);
               acc_d    = wdata_q;
               state_d  = S_DONE;
            end
         end
         S_GAP: begin
            if (gap_q <= CNT_W'(1)) begin
               arvalid_d = 1'b1;
               state_d   = S_AR;
            end else begin
               gap_d = gap_q - CNT_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         op_q      <= OP_READ;
         addr_q    <= '0;
         mask_q    <= '0;
         wdata_q   <= '0;
         acc_q     <= '0;
         err_q     <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         bready_q  <= 1'b0;
         rready_q  <= 1'b0;
         gap_q     <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         mask_q    <= mask_d;
         wdata_q   <= wdata_d;
         acc_q     <= acc_d;
         err_q     <= err_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         arvalid_q <= arvalid_d;
         bready_q  <= bready_d;
         rready_q  <= rready_d;
         gap_q     <= gap_d;
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_DONE);
   assign rsp_data  = acc_q;
   assign rsp_err   = err_q;

   assign m_awaddr  = addr_q;
   assign m_araddr  = addr_q;
   assign m_awprot  = 3'b000;
   assign m_arprot  = 3'b000;
   assign m_wdata   = wdata_q;
   assign m_wstrb   = '1;
   assign m_awvalid = awvalid_q;
   assign m_wvalid  = wvalid_q;
   assign m_arvalid = arvalid_q;
   assign m_bready  = bready_q;
   assign m_rready  = rready_q;

endmodule

// File: tb/tb_axil_reg_manager.sv
// Bench for axil_reg_manager: AXI4-Lite RAM subordinate with random ready delays,
// register-level reference model and a protocol monitor.
module tb_axil_reg_manager;

   localparam int DW = 32;
   localparam int AW = 8;
   localparam int PC = 100;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [2:0]    cmd_op = 3'd0;
   logic [AW-1:0] cmd_reg = '0;
   logic [DW-1:0] cmd_data = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          rsp_err;
   logic [AW-1:0] m_awaddr, m_araddr;
   logic [2:0]    m_awprot, m_arprot;
   logic          m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic          m_arvalid, m_arready, m_rvalid, m_rready;
   logic [DW-1:0] m_wdata, m_rdata;
   logic [3:0]    m_wstrb;
   logic [1:0]    m_bresp, m_rresp;

   always #5 clk = ~clk;

   axil_reg_manager #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .POLL_CYCLES(PC)) dut (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_reg(cmd_reg), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
   );

   // ---------------- subordinate RAM model ----------------
   int            cyc = 0;
   int            aw_fix = 0, w_fix = 0, ar_fix = 0, r_fix = 0, b_fix = 0;
   int            err_idx = -1;
   int            poll_at = -1;
   int            writes = 0;
   int            aw_cnt, w_cnt, ar_cnt, r_cnt, b_cnt;
   logic          aw_have, w_have, b_pend, r_pend;
   logic [AW-1:0] aw_addr_s, last_awaddr = '0;
   logic [DW-1:0] w_data_s, r_data_s;
   logic [1:0]    r_resp_s;
   logic [DW-1:0] sub_mem [64] = '{default: '0};
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          aw_hs, w_hs;

   function automatic int pick(input int fix);
      return (fix >= 0) ? fix : int'($urandom_range(0, 5));
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   assign m_awready = !aw_have && (aw_cnt == 0);
   assign m_wready  = !w_have && (w_cnt == 0);
   assign m_arready = !r_pend && (ar_cnt == 0);
   assign m_bvalid  = b_pend && (b_cnt == 0);
   assign m_rvalid  = r_pend && (r_cnt == 0);
   assign m_bresp   = 2'b00;
   assign m_rdata   = r_data_s;
   assign m_rresp   = r_resp_s;
   assign aw_hs     = m_awvalid && m_awready;
   assign w_hs      = m_wvalid && m_wready;
   assign wr_addr   = aw_have ? aw_addr_s : m_awaddr;
   assign wr_data   = w_have ? w_data_s : m_wdata;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         aw_have <= 1'b0; w_have <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0; b_cnt <= 0;
         aw_addr_s <= '0; w_data_s <= '0; r_data_s <= '0; r_resp_s <= 2'b00;
      end else begin
         if (aw_hs) begin
            aw_have <= 1'b1; aw_addr_s <= m_awaddr; last_awaddr <= m_awaddr;
         end else if (!m_awvalid) aw_cnt <= pick(aw_fix);
         else if (aw_cnt > 0) aw_cnt <= aw_cnt - 1;
         if (w_hs) begin
            w_have <= 1'b1; w_data_s <= m_wdata;
         end else if (!m_wvalid) w_cnt <= pick(w_fix);
         else if (w_cnt > 0) w_cnt <= w_cnt - 1;
         // Commit as soon as both halves are in, so B can answer with zero delay
         if ((aw_have || aw_hs) && (w_have || w_hs) && !b_pend) begin
            sub_mem[wr_addr[AW-1:2]] <= wr_data;
            writes <= writes + 1;
            b_pend <= 1'b1;
            b_cnt  <= pick(b_fix);
         end else if (b_pend) begin
            if (m_bvalid && m_bready) begin
               b_pend <= 1'b0; aw_have <= 1'b0; w_have <= 1'b0;
            end else if (b_cnt > 0) b_cnt <= b_cnt - 1;
         end
         if (m_arvalid && m_arready) begin
            r_pend   <= 1'b1;
            r_cnt    <= pick(r_fix);
            r_data_s <= sub_mem[m_araddr[AW-1:2]];
            r_resp_s <= (int'(m_araddr[AW-1:2]) == err_idx) ? 2'b10 : 2'b00;
         end else if (!m_arvalid) ar_cnt <= pick(ar_fix);
         else if (ar_cnt > 0) ar_cnt <= ar_cnt - 1;
         if (r_pend) begin
            if (m_rvalid && m_rready) r_pend <= 1'b0;
            else if (r_cnt > 0) r_cnt <= r_cnt - 1;
         end
         if (cyc == poll_at) sub_mem[2] <= sub_mem[2] | 32'h4;
      end
   end

   // ---------------- protocol monitor ----------------
   int            viol = 0;
   logic          aw_pend_m = 1'b0, w_pend_m = 1'b0, ar_pend_m = 1'b0;
   logic [AW-1:0] awaddr_m = '0, araddr_m = '0;
   logic [DW-1:0] wdata_m = '0;
   logic          aw_bad, w_bad, ar_bad, b_bad;

   assign aw_bad = aw_pend_m && (!m_awvalid || (m_awaddr != awaddr_m));
   assign w_bad  = w_pend_m && (!m_wvalid || (m_wdata != wdata_m));
   assign ar_bad = ar_pend_m && (!m_arvalid || (m_araddr != araddr_m));
   assign b_bad  = m_bready && (m_awvalid || m_wvalid);

   always @(posedge clk) begin
      if (!resetn) begin
         aw_pend_m <= 1'b0; w_pend_m <= 1'b0; ar_pend_m <= 1'b0;
      end else begin
         viol      <= viol + int'(aw_bad) + int'(w_bad) + int'(ar_bad) + int'(b_bad);
         aw_pend_m <= m_awvalid && !m_awready;
         w_pend_m  <= m_wvalid && !m_wready;
         ar_pend_m <= m_arvalid && !m_arready;
         awaddr_m  <= m_awaddr;
         wdata_m   <= m_wdata;
         araddr_m  <= m_araddr;
      end
   end

   // ---------------- checking and reference model ----------------
   int            total = 0;
   int            bad = 0;
   logic [DW-1:0] ref_mem [64];
   logic [DW-1:0] last_rsp = '0;
   int            last_lat, nreads, min_gap, last_r;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   function automatic int ridx(input logic [AW-1:0] rg);
      int byte_addr;
      byte_addr = (int'(rg) * (DW / 8)) % (1 << AW);
      return byte_addr / (DW / 8);
   endfunction

   // Issue one command; lat counts clocks inclusively from the accepting cycle to rsp_valid
   task automatic do_cmd(input logic [2:0] op, input logic [AW-1:0] rg, input logic [DW-1:0] d,
                         output logic [DW-1:0] rd, output logic er, output int lat);
      int  n;
      bit  got;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_reg = rg; cmd_data = d;
      n = 0;
      while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 2; nreads = 0; min_gap = 1 << 30; last_r = -1; got = 1'b0;
      while (lat < 5000) begin
         if (m_arvalid && m_arready && last_r >= 0 && (lat - last_r) < min_gap) min_gap = lat - last_r;
         if (m_rvalid && m_rready) begin nreads++; last_r = lat; end
         if (rsp_valid) begin got = 1'b1; break; end
         @(negedge clk);
         lat++;
      end
      if (!got) check("rsp_timeout", 32'd0, 32'd1);
      rd = rsp_data;
      er = rsp_err;
      @(negedge clk);
      check("rsp_pulse", 32'(rsp_valid), 32'd0);
   endtask

   task automatic run(input logic [2:0] op, input logic [AW-1:0] rg, input logic [DW-1:0] d, input string tag);
      logic [DW-1:0] exp_d, got_d, v;
      logic          exp_e, got_e;
      int            i;
      i = ridx(rg);
      v = ref_mem[i];
      exp_e = (i == err_idx);
      case (op)
         3'd0:    exp_d = v;
         3'd1:    begin exp_d = d; exp_e = 1'b0; end
         3'd2:    exp_d = v | d;
         3'd3:    exp_d = v & ~d;
         3'd4:    exp_d = v;
         default: begin exp_d = last_rsp; exp_e = 1'b1; end
      endcase
      if (op == 3'd1 || op == 3'd2 || op == 3'd3) ref_mem[i] = exp_d;
      do_cmd(op, rg, d, got_d, got_e, last_lat);
      $display("cmd %-10s op=%0d reg=%3d data=%08h -> rsp=%08h err=%0b lat=%0d",
               tag, op, rg, d, got_d, got_e, last_lat);
      check({tag, "_data"}, got_d, exp_d);
      check({tag, "_err"}, 32'(got_e), 32'(exp_e));
      last_rsp = exp_d;
   endtask

   initial begin
      int            wc, n;
      logic [2:0]    op;
      logic [AW-1:0] rg;
      logic [DW-1:0] d;

      for (int i = 0; i < 64; i++) ref_mem[i] = '0;
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valids", 32'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 32'd0);
      resetn = 1'b1;
      @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_wstrb", 32'(m_wstrb), 32'hF);
      check("rst_addr_prot", 32'({m_awaddr, m_araddr, m_awprot, m_arprot}), 32'd0);
      check("rst_wdata", m_wdata, 32'd0);

      // subordinate ready effectively tied high
      run(3'd1, 8'd6, 32'h01020304, "wr6");
      check("wr6_awaddr", 32'(last_awaddr), 32'h18);
      check("wr6_lat", 32'(last_lat), 32'd4);
      run(3'd0, 8'd6, 32'h0, "rd6");
      check("rd6_lat", 32'(last_lat), 32'd4);

      // AW/W skew in both directions
      aw_fix = 0; w_fix = 3;
      wc = writes;
      run(3'd1, 8'd7, 32'hA5A5A5A5, "skew_aw");
      check("skew_aw_writes", 32'(writes - wc), 32'd1);
      aw_fix = 3; w_fix = 0;
      wc = writes;
      run(3'd1, 8'd7, 32'h5A5A5A5A, "skew_w");
      check("skew_w_writes", 32'(writes - wc), 32'd1);
      run(3'd0, 8'd7, 32'h0, "rd7");

      // random ready delays from here on
      aw_fix = -1; w_fix = -1; ar_fix = -1; r_fix = -1; b_fix = -1;
      run(3'd1, 8'd2, 32'h00000010, "init2");
      run(3'd2, 8'd2, 32'h00000001, "set2");
      run(3'd3, 8'd2, 32'h00000010, "clr2");
      run(3'd0, 8'd2, 32'h0, "rdback2");

      // POLL: subordinate raises bit 2 after 350 clocks
      poll_at = cyc + 350;
      ref_mem[2] = ref_mem[2] | 32'h4;
      run(3'd4, 8'd2, 32'h4, "poll2");
      check("poll2_multi_read", 32'(nreads >= 2), 32'd1);
      check("poll2_gap", 32'(min_gap >= PC), 32'd1);
      poll_at = -1;

      // SLVERR on reads of register 5
      err_idx = 5;
      run(3'd0, 8'd5, 32'h0, "slverr_rd");
      run(3'd4, 8'd5, 32'h80000000, "slverr_pl");
      check("slverr_pl_reads", 32'(nreads), 32'd1);
      err_idx = -1;

      run(3'd4, 8'd3, 32'h0, "poll_m0");
      check("poll_m0_reads", 32'(nreads), 32'd1);

      wc = writes;
      run(3'd6, 8'd4, 32'h12345678, "illegal");
      check("illegal_bus", 32'(nreads + (writes - wc)), 32'd0);

      for (int k = 0; k < 40; k++) begin
         op = 3'($urandom_range(0, 5));
         if (op == 3'd5) op = 3'($urandom_range(5, 7));
         rg = AW'($urandom_range(0, 255));
         d  = $urandom;
         if (op == 3'd4) d = ref_mem[ridx(rg)] & $urandom;
         run(op, rg, d, "rand");
      end

      // reset while waiting on B
      b_fix = 5;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd1; cmd_reg = 8'd9; cmd_data = 32'hDEADBEEF;
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (!m_bready && n < 50) begin @(negedge clk); n++; end
      check("bwait_reached", 32'(m_bready), 32'd1);
      resetn = 1'b0;
      #1;
      check("rstB_valids", 32'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 32'd0);
      check("rstB_idle", 32'(cmd_ready), 32'd1);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      b_fix = -1;
      last_rsp = '0;
      run(3'd1, 8'd9, 32'h13572468, "post_rst_wr");
      run(3'd0, 8'd9, 32'h0, "post_rst_rd");

      check("protocol_viol", 32'(viol), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
